sdram_clkdiv_gen: RTL and testbench



---
 rtl/sdram_clkdiv_gen_if.sv | 24 ++
 rtl/sdram_clkdiv_gen.sv | 141 ++++++++++++++
 tb/tb_sdram_clkdiv_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_clkdiv_gen_if.sv
// rtl/sdram_clkdiv_gen_if.sv - configuration handshake bundle for sdram_clkdiv_gen
interface sdram_clkdiv_gen_if #(
    parameter int NUM_CLOCKS = 3,
    parameter int DIV_W      = 8
);
    localparam int CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_chan, cfg_div, cfg_phase,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_div, cfg_phase,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/sdram_clkdiv_gen.sv
// rtl/sdram_clkdiv_gen.sv - reprogrammable multi-channel clock-strobe generator
// Optional reconfiguration counter output enabled by SDRAM_CLKDIV_RECFG_CNT_EN.
module sdram_clkdiv_gen #(
    parameter int NUM_CLOCKS  = 3,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int LOCK_CYCLES = 64
) (
    input  logic                  refclk,
    input  logic                  rst,
    sdram_clkdiv_gen_if.slave     cfg_if,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_en,
`ifdef SDRAM_CLKDIV_RECFG_CNT_EN
    output logic [7:0]            recfg_cnt,
`endif
    output logic                  locked
);
    localparam int CH_W  = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam logic [CH_W:0] NUM_C = NUM_CLOCKS[CH_W:0];

    typedef enum logic [1:0] {SETTLE, LOCKED, APPLY} state_t;

    state_t                 state_q, state_d;
    logic [SET_W-1:0]       settle_q, settle_d;
    logic [DIV_W-1:0]       div_q   [NUM_CLOCKS];
    logic [DIV_W-1:0]       div_d   [NUM_CLOCKS];
    logic [DIV_W-1:0]       phase_q [NUM_CLOCKS];
    logic [DIV_W-1:0]       phase_d [NUM_CLOCKS];
    logic [DIV_W-1:0]       cnt_q   [NUM_CLOCKS];
    logic [DIV_W-1:0]       cnt_d   [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0]  outclk_q, outclk_d, outclk_en_q, outclk_en_d;
    logic                   locked_q, locked_d, ready_q, ready_d, err_q, err_d;
    logic [7:0]             recfg_q, recfg_d;
    logic                   accept, bad;

    // Phase P delays the first rising edge by P cycles, so the counter starts P short of a wrap.
    function automatic logic [DIV_W-1:0] start_val(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] p);
        return (p == '0) ? '0 : d - p;
    endfunction

    assign accept = cfg_if.cfg_valid && ready_q;
    assign bad    = (cfg_if.cfg_div < DIV_W'(2)) || (cfg_if.cfg_phase >= cfg_if.cfg_div)
                 || ({1'b0, cfg_if.cfg_chan} >= NUM_C);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        div_d       = div_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        outclk_d    = outclk_q;
        outclk_en_d = outclk_en_q;
        locked_d    = locked_q;
        ready_d     = ready_q;
        err_d       = 1'b0;
        recfg_d     = recfg_q;
        if (state_q == APPLY) begin
            for (int i = 0; i < NUM_CLOCKS; i++) cnt_d[i] = start_val(div_q[i], phase_q[i]);
            outclk_d    = '0;
            outclk_en_d = '0;
            settle_d    = '0;
            locked_d    = 1'b0;
            ready_d     = 1'b1;
            state_d     = SETTLE;
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                cnt_d[i]       = (cnt_q[i] == div_q[i] - DIV_W'(1)) ? '0 : cnt_q[i] + DIV_W'(1);
                outclk_d[i]    = cnt_q[i] < (div_q[i] >> 1);
                outclk_en_d[i] = cnt_q[i] == '0;
            end
            ready_d = 1'b1;
            if (state_q == SETTLE) begin
                settle_d = settle_q + SET_W'(1);
                if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end
            end
            if (accept) begin
                if (bad) begin
                    err_d = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_CLOCKS; i++) begin
                        if (CH_W'(i) == cfg_if.cfg_chan) begin
                            div_d[i]   = cfg_if.cfg_div;
                            phase_d[i] = cfg_if.cfg_phase;
                        end
                    end
                    state_d  = APPLY;
                    ready_d  = 1'b0;
                    locked_d = 1'b0;
                    if (recfg_q != 8'hff) recfg_d = recfg_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= SETTLE;
            settle_q    <= '0;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                div_q[i]   <= DIV_W'(DEFAULT_DIV);
                phase_q[i] <= '0;
                cnt_q[i]   <= start_val(DIV_W'(DEFAULT_DIV), '0);
            end
            outclk_q    <= '0;
            outclk_en_q <= '0;
            locked_q    <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            recfg_q     <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            outclk_q    <= outclk_d;
            outclk_en_q <= outclk_en_d;
            locked_q    <= locked_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            recfg_q     <= recfg_d;
        end
    end

    assign outclk           = outclk_q;
    assign outclk_en        = outclk_en_q;
    assign locked           = locked_q;
    assign cfg_if.cfg_ready = ready_q;
    assign cfg_if.cfg_err   = err_q;
`ifdef SDRAM_CLKDIV_RECFG_CNT_EN
    assign recfg_cnt        = recfg_q;
`else
    logic unused_recfg;
    assign unused_recfg     = ^recfg_q;
`endif
endmodule

// File: tb/tb_sdram_clkdiv_gen.sv
// tb/tb_sdram_clkdiv_gen.sv - scoreboard bench for sdram_clkdiv_gen
module tb_sdram_clkdiv_gen;
    localparam int NC   = 3;
    localparam int LOCK = 8;

    logic          refclk = 1'b0;
    logic          rst    = 1'b1;
    logic [NC-1:0] outclk, outclk_en;
    logic          locked;
`ifdef SDRAM_CLKDIV_RECFG_CNT_EN
    logic [7:0]    recfg_cnt;
`endif

    sdram_clkdiv_gen_if #(.NUM_CLOCKS(NC), .DIV_W(8)) cfg_if ();

    sdram_clkdiv_gen #(.NUM_CLOCKS(NC), .DIV_W(8), .DEFAULT_DIV(4), .LOCK_CYCLES(LOCK)) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_if    (cfg_if.slave),
        .outclk    (outclk),
        .outclk_en (outclk_en),
`ifdef SDRAM_CLKDIV_RECFG_CNT_EN
        .recfg_cnt (recfg_cnt),
`endif
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [NC-1:0] oc;
        logic [NC-1:0] en;
        logic          lk;
        logic          rd;
        logic          er;
        int            rc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Expectation tracking: k counts edges since the last realignment (0 = realign edge).
    int  k = 0;
    bit  rdy = 0, pend = 0, lockx = 0, errx = 0;
    int  s_div[NC], s_ph[NC], a_div[NC], a_ph[NC];
    int  rc = 0;

    task automatic tick(input bit r, input bit v, input int ch, input int d, input int p);
        exp_t e;
        int   idx;
        @(negedge refclk);
        rst              = r;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_chan  = ch[1:0];
        cfg_if.cfg_div   = d[7:0];
        cfg_if.cfg_phase = p[7:0];
        @(posedge refclk);
        errx = 0;
        if (r) begin
            k = 0; rdy = 0; pend = 0; lockx = 0; rc = 0;
            for (int i = 0; i < NC; i++) begin
                s_div[i] = 4; s_ph[i] = 0; a_div[i] = 4; a_ph[i] = 0;
            end
        end else if (pend) begin
            k = 0; rdy = 1; pend = 0; lockx = 0;
            for (int i = 0; i < NC; i++) begin
                a_div[i] = s_div[i]; a_ph[i] = s_ph[i];
            end
        end else begin
            k++;
            if (v && rdy) begin
                if (d < 2 || p >= d || ch >= NC) errx = 1;
                else begin
                    s_div[ch] = d; s_ph[ch] = p; pend = 1;
                    if (rc < 255) rc++;
                end
            end
            rdy   = !pend;
            lockx = !pend && (k >= LOCK);
        end
        for (int i = 0; i < NC; i++) begin
            if (k == 0) begin
                e.oc[i] = 1'b0; e.en[i] = 1'b0;
            end else begin
                idx = (((k - 1 - a_ph[i]) % a_div[i]) + a_div[i]) % a_div[i];
                e.oc[i] = (idx < a_div[i] / 2);
                e.en[i] = (idx == 0);
            end
        end
        e.lk = lockx; e.rd = rdy; e.er = errx; e.rc = rc;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        int   cyc = 0;
        forever begin
            @(negedge refclk);
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (outclk !== e.oc) begin
                    fails++;
                    $display("FAIL outclk cyc=%0d got=%b want=%b", cyc, outclk, e.oc);
                end
                tests++;
                if (outclk_en !== e.en) begin
                    fails++;
                    $display("FAIL outclk_en cyc=%0d got=%b want=%b", cyc, outclk_en, e.en);
                end
                tests++;
                if (locked !== e.lk) begin
                    fails++;
                    $display("FAIL locked cyc=%0d got=%b want=%b", cyc, locked, e.lk);
                end
                tests++;
                if (cfg_if.cfg_ready !== e.rd) begin
                    fails++;
                    $display("FAIL cfg_ready cyc=%0d got=%b want=%b", cyc, cfg_if.cfg_ready, e.rd);
                end
                tests++;
                if (cfg_if.cfg_err !== e.er) begin
                    fails++;
                    $display("FAIL cfg_err cyc=%0d got=%b want=%b", cyc, cfg_if.cfg_err, e.er);
                end
`ifdef SDRAM_CLKDIV_RECFG_CNT_EN
                tests++;
                if (recfg_cnt !== e.rc[7:0]) begin
                    fails++;
                    $display("FAIL recfg_cnt cyc=%0d got=%0d want=%0d", cyc, recfg_cnt, e.rc);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        int wait_cyc;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_chan  = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_phase = '0;

        // Reset release with defaults, settle into lock.
        repeat (3) tick(1, 0, 0, 0, 0);
        idle(20);

        // Reprogram channel 1 while locked.
        tick(0, 1, 1, 5, 2);
        idle(25);

        // Illegal requests: div below 2, phase not below div, channel out of range.
        tick(0, 1, 0, 1, 0); idle(3);
        tick(0, 1, 0, 4, 4); idle(3);
        tick(0, 1, 3, 4, 0); idle(3);

        // Back-to-back with valid held high across the APPLY cycle.
        tick(0, 1, 2, 6, 1);
        tick(0, 1, 2, 6, 1);
        tick(0, 1, 0, 3, 1);
        idle(15);

        // Reset sampled during APPLY.
        tick(0, 1, 1, 7, 3);
        tick(1, 0, 0, 0, 0);
        idle(14);

        // Reset sampled mid-SETTLE.
        tick(0, 1, 0, 5, 4);
        idle(4);
        tick(1, 0, 0, 0, 0);
        idle(14);

`ifdef SDRAM_CLKDIV_RECFG_CNT_EN
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 3, 0); tick(0, 0, 0, 0, 0);
        tick(0, 1, 1, 6, 5); tick(0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0); tick(0, 0, 0, 0, 0);
        tick(0, 1, 2, 2, 1); tick(0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 300; i++) begin
            tick(0, 1, i % NC, 2 + (i % 5), i % 2);
            tick(0, 0, 0, 0, 0);
        end
        idle(12);
`endif

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(negedge refclk);
            wait_cyc++;
        end
        @(negedge refclk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
